// File: rtl/uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter : round-robin arbiter feeding one UART transmitter         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int BIT_MAX     = 8,
    parameter int ACC_TIMEOUT = 16,
    parameter int GAP_CYCLES  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BIT_MAX-1:0] req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic [BIT_MAX-1:0]         tx_data,
    output logic                       tx_start,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       err,
    output logic [15:0]                frame_cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int ACC_W = (ACC_TIMEOUT > 1) ? $clog2(ACC_TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PTR_W:0]   C_NUM      = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W:0]   C_ONE      = (PTR_W+1)'(1);
    localparam logic [ACC_W-1:0] C_ACC_LAST = ACC_W'(ACC_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACC  = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [PTR_W-1:0]     r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
    logic [BIT_MAX-1:0]   r_tx_data, w_tx_data_nxt;
    logic                 r_tx_start, w_tx_start_nxt;
    logic                 r_busy;
    logic                 r_err, w_err_nxt;
    logic [15:0]          r_frame_cnt;
    logic                 w_frame_inc;
    logic [ACC_W-1:0]     r_acc_cnt, w_acc_cnt_nxt;
    logic [GAP_W-1:0]     r_gap_cnt, w_gap_cnt_nxt;

    logic [2*NUM_REQ-1:0] w_req2;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PTR_W-1:0]     w_off;
    logic [PTR_W:0]       w_sum;
    logic [PTR_W-1:0]     w_winner;
    logic [PTR_W-1:0]     w_ptr_after;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [BIT_MAX-1:0]   w_sel;

    // Rotate requests so bit 0 is the requester at ptr, then take the lowest set bit.
    always_comb begin
        w_req2 = {req, req};
        w_rot  = NUM_REQ'(w_req2 >> r_ptr);
        w_off  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = PTR_W'(k);
        end
        w_sum       = {1'b0, r_ptr} + {1'b0, w_off};
        w_winner    = PTR_W'((w_sum >= C_NUM) ? (w_sum - C_NUM) : w_sum);
        w_ptr_after = (({1'b0, w_winner} + C_ONE) >= C_NUM) ? '0 : (w_winner + PTR_W'(1));
        w_onehot           = '0;
        w_onehot[w_winner] = 1'b1;
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_onehot[i]) w_sel = req_data[i*BIT_MAX +: BIT_MAX];
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = '0;
        w_tx_data_nxt  = r_tx_data;
        w_tx_start_nxt = r_tx_start;
        w_err_nxt      = 1'b0;
        w_acc_cnt_nxt  = r_acc_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_frame_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_ready && (req != '0)) begin
                    w_grant_nxt    = w_onehot;
                    w_tx_data_nxt  = w_sel;
                    w_tx_start_nxt = 1'b1;
                    w_ptr_nxt      = w_ptr_after;
                    w_acc_cnt_nxt  = '0;
                    w_state_nxt    = S_WAIT_ACC;
                end
            end
            S_WAIT_ACC: begin
                if (!tx_ready) begin
                    w_tx_start_nxt = 1'b0;
                    w_state_nxt    = S_WAIT_DONE;
                end else if (r_acc_cnt == C_ACC_LAST) begin
                    // Transmitter never went busy: give up, keep the advanced ptr.
                    w_err_nxt      = 1'b1;
                    w_tx_start_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_acc_cnt_nxt = r_acc_cnt + ACC_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (tx_ready) begin
                    w_frame_inc = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        w_gap_cnt_nxt = '0;
                        w_state_nxt   = S_GAP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == C_GAP_LAST) w_state_nxt = S_IDLE;
                else                         w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_acc_cnt   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_err      <= w_err_nxt;
            r_acc_cnt  <= w_acc_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign grant     = r_grant;
    assign tx_data   = r_tx_data;
    assign tx_start  = r_tx_start;
    assign busy      = r_busy;
    assign err       = r_err;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_arbiter : directed self-checking bench for uart_tx_arbiter      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, req_g;
    logic [N*W-1:0] req_data, req_data_g;
    logic           tx_ready, tx_ready_g;
    logic [N-1:0]   grant, grant_g;
    logic [W-1:0]   tx_data, tx_data_g;
    logic           tx_start, tx_start_g, busy, busy_g, err, err_g;
    logic [15:0]    frame_cnt, frame_cnt_g;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .BIT_MAX(W), .ACC_TIMEOUT(16), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
        .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready), .busy(busy),
        .err(err), .frame_cnt(frame_cnt)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .BIT_MAX(W), .ACC_TIMEOUT(16), .GAP_CYCLES(3)) dut_g (
        .clk(clk), .rst(rst), .req(req_g), .req_data(req_data_g), .grant(grant_g),
        .tx_data(tx_data_g), .tx_start(tx_start_g), .tx_ready(tx_ready_g), .busy(busy_g),
        .err(err_g), .frame_cnt(frame_cnt_g)
    );

    // Outputs are sampled 1ns after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; req_g = '0; req_data = '0; req_data_g = '0;
        tx_ready = 1'b0; tx_ready_g = 1'b0;
        tick(); tick();
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_chk++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        n_chk++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_chk++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_frame_cnt: got %h want 0000", frame_cnt); end
        rst = 1'b1;
        tick();
        n_chk++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL idle_no_req: busy %b grant %b want 0 0000", busy, grant); end
    endtask

    task automatic test_single();
        req = 4'b0100; req_data = 32'h005A_0000; tx_ready = 1'b1;
        tick();
        n_chk++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant); end
        n_chk++; if (tx_data !== 8'h5A) begin n_fail++; $display("FAIL single_tx_data: got %h want 5a", tx_data); end
        n_chk++; if (tx_start !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_start: start %b busy %b want 1 1", tx_start, busy); end
        req = '0;
        tick();
        n_chk++; if (grant !== 4'b0000 || tx_start !== 1'b1) begin n_fail++; $display("FAIL single_hold: grant %b start %b want 0000 1", grant, tx_start); end
        tx_ready = 1'b0;
        tick();
        n_chk++; if (tx_start !== 1'b0 || tx_data !== 8'h5A || busy !== 1'b1) begin
            n_fail++; $display("FAIL single_accept: start %b data %h busy %b want 0 5a 1", tx_start, tx_data, busy); end
        n_chk++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL single_cnt_early: got %0d want 0", frame_cnt); end
        tick();
        tx_ready = 1'b1;
        tick();
        n_chk++; if (frame_cnt !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_done: cnt %0d busy %b want 1 0", frame_cnt, busy); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        logic [W-1:0] exp_d;
        int waited;
        bit found;
        rst = 1'b0;
        tick();
        rst = 1'b1; req = 4'b1111; req_data = 32'h1312_1110; tx_ready = 1'b1;
        for (int f = 0; f < 5; f++) begin
            exp_g = 4'b0001 << (f % 4);
            exp_d = 8'(16 + f % 4);
            waited = 0; found = 1'b0;
            for (int t = 0; t < 30 && !found; t++) begin
                tick(); waited++;
                if (grant !== 4'b0000) found = 1'b1;
            end
            n_chk++; if (grant !== exp_g || tx_data !== exp_d) begin
                n_fail++; $display("FAIL rr_grant_%0d: grant %b data %h want %b %h", f, grant, tx_data, exp_g, exp_d); end
            n_chk++; if (waited != ((f == 0) ? 1 : 2)) begin
                n_fail++; $display("FAIL rr_spacing_%0d: got %0d want %0d", f, waited, (f == 0) ? 1 : 2); end
            if (f == 4) req = '0;
            tx_ready = 1'b0;
            tick();
            n_chk++; if (grant !== 4'b0000 || tx_start !== 1'b0) begin
                n_fail++; $display("FAIL rr_pulse_%0d: grant %b start %b want 0000 0", f, grant, tx_start); end
            repeat (9) tick();
            tx_ready = 1'b1;
        end
        tick();
        n_chk++; if (frame_cnt !== 16'd5 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_count: cnt %0d busy %b want 5 0", frame_cnt, busy); end
    endtask

    task automatic test_timeout();
        int cnt;
        bit found;
        req = 4'b1111; tx_ready = 1'b1;
        tick();
        n_chk++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL to_grant: got %b want 0010", grant); end
        cnt = 0; found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
            tick(); cnt++;
            if (err === 1'b1) found = 1'b1;
        end
        n_chk++; if (!found || cnt != 16) begin n_fail++; $display("FAIL to_latency: got %0d (seen %0d) want 16", cnt, found); end
        n_chk++; if (tx_start !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd5) begin
            n_fail++; $display("FAIL to_state: start %b busy %b cnt %0d want 0 0 5", tx_start, busy, frame_cnt); end
        tick();
        n_chk++; if (err !== 1'b0 || grant !== 4'b0100) begin n_fail++; $display("FAIL to_next: err %b grant %b want 0 0100", err, grant); end
        req = '0; tx_ready = 1'b0;
        tick();
        tx_ready = 1'b1;
        tick();
        n_chk++; if (frame_cnt !== 16'd6) begin n_fail++; $display("FAIL to_resume_cnt: got %0d want 6", frame_cnt); end
    endtask

    task automatic test_reset_mid();
        req = 4'b0010; tx_ready = 1'b1;
        tick();
        n_chk++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rm_grant: got %b want 0010", grant); end
        req = '0; tx_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        n_chk++; if ({grant, tx_data, tx_start, busy, err, frame_cnt} !== '0) begin
            n_fail++; $display("FAIL rm_outputs: g %b d %h s %b b %b e %b c %h want all 0", grant, tx_data, tx_start, busy, err, frame_cnt); end
        rst = 1'b1; tx_ready = 1'b1; req = 4'b1000; req_data = 32'hA500_0000;
        tick();
        n_chk++; if (grant !== 4'b1000 || tx_data !== 8'hA5) begin n_fail++; $display("FAIL rm_regrant: grant %b data %h want 1000 a5", grant, tx_data); end
        req = '0; tx_ready = 1'b0;
        tick();
        tx_ready = 1'b1;
        tick();
        n_chk++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rm_count: got %0d want 1", frame_cnt); end
    endtask

    task automatic test_wrap();
        force dut.r_frame_cnt = 16'hFFFE;
        #1;
        release dut.r_frame_cnt;
        req_data = 32'h0000_00C3;
        for (int f = 0; f < 2; f++) begin
            req = 4'b0001; tx_ready = 1'b1;
            tick();
            n_chk++; if (grant !== 4'b0001 || tx_data !== 8'hC3) begin
                n_fail++; $display("FAIL wrap_grant_%0d: grant %b data %h want 0001 c3", f, grant, tx_data); end
            req = '0; tx_ready = 1'b0;
            tick();
            tx_ready = 1'b1;
            tick();
        end
        n_chk++; if (frame_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got %h want 0000", frame_cnt); end
        n_chk++; if (busy !== 1'b0 || err !== 1'b0 || grant !== 4'b0000) begin
            n_fail++; $display("FAIL wrap_side: busy %b err %b grant %b want 0 0 0000", busy, err, grant); end
    endtask

    task automatic test_gap();
        int cnt;
        bit found;
        req_g = 4'b0001; req_data_g = 32'h0000_007E; tx_ready_g = 1'b1;
        tick();
        n_chk++; if (grant_g !== 4'b0001 || tx_data_g !== 8'h7E || tx_start_g !== 1'b1) begin
            n_fail++; $display("FAIL gap_grant: grant %b data %h start %b want 0001 7e 1", grant_g, tx_data_g, tx_start_g); end
        tx_ready_g = 1'b0;
        tick();
        tx_ready_g = 1'b1;
        tick();
        n_chk++; if (frame_cnt_g !== 16'd1 || busy_g !== 1'b1 || err_g !== 1'b0) begin
            n_fail++; $display("FAIL gap_enter: cnt %0d busy %b err %b want 1 1 0", frame_cnt_g, busy_g, err_g); end
        cnt = 0; found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            tick(); cnt++;
            if (grant_g !== 4'b0000) found = 1'b1;
        end
        n_chk++; if (!found || cnt != 4 || grant_g !== 4'b0001) begin
            n_fail++; $display("FAIL gap_spacing: got %0d cycles grant %b want 4 0001", cnt, grant_g); end
        req_g = '0; tx_ready_g = 1'b0;
        tick();
        tx_ready_g = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_wrap();
        test_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
